rob_pr_free_q: RTL and testbench

- Consumer end of the ROB commit → free-list PR deallocation path.
- The ROB presents up to 4 freed physical registers per cycle. This block steers each one to a per-bank FIFO using PR[LOG_PRF_BANK_COUNT-1:0].
- Each FIFO drains one PR per cycle into its free_list bank under valid/ready.
- It decouples 4-wide commit bursts from the 1-per-bank free-list enqueue rate.

---
 rtl/rob_pr_free_q.sv | 141 ++++++++++++++
 tb/tb_rob_pr_free_q.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_pr_free_q.sv
// Per-bank FIFOs between ROB commit deallocation and free-list banks.
// Optional perf counters are compiled in with `define ROB_PR_FREE_Q_PERF_EN.
module rob_pr_free_q #(
   parameter int COMMIT_WIDTH     = 4,
   parameter int PR_COUNT         = 128,
   parameter int PRF_BANK_COUNT   = 4,
   parameter int ENTRIES_PER_BANK = 8,
   localparam int LOG_PR_COUNT    = $clog2(PR_COUNT),
   localparam int LOG_BANK        = $clog2(PRF_BANK_COUNT),
   localparam int PTR_W           = $clog2(ENTRIES_PER_BANK),
   localparam int OCC_W           = $clog2(ENTRIES_PER_BANK + 1)
) (
   input  logic                                         CLK,
   input  logic                                         RST,
   input  logic [COMMIT_WIDTH-1:0]                      dealloc_valid_by_lane,
   input  logic [COMMIT_WIDTH-1:0][LOG_PR_COUNT-1:0]    dealloc_pr_by_lane,
   output logic                                         dealloc_ready,
   output logic [PRF_BANK_COUNT-1:0]                    free_valid_by_bank,
   output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  free_pr_by_bank,
   input  logic [PRF_BANK_COUNT-1:0]                    free_ready_by_bank,
   output logic [PRF_BANK_COUNT-1:0][OCC_W-1:0]         occupancy_by_bank
`ifdef ROB_PR_FREE_Q_PERF_EN
   ,
   output logic [31:0]                                  perf_stall_cycles,
   output logic [OCC_W-1:0]                             perf_max_occupancy
`endif
);

   logic [LOG_PR_COUNT-1:0] mem [PRF_BANK_COUNT][ENTRIES_PER_BANK];

   logic [PRF_BANK_COUNT-1:0][PTR_W-1:0] head;
   logic [PRF_BANK_COUNT-1:0][PTR_W-1:0] tail;
   logic [PRF_BANK_COUNT-1:0][OCC_W-1:0] occ;

   logic [COMMIT_WIDTH-1:0][LOG_BANK-1:0] lane_bank;
   logic [COMMIT_WIDTH-1:0][PTR_W-1:0]    lane_offset;
   logic [PRF_BANK_COUNT-1:0][OCC_W-1:0]  enq_count;
   logic [PRF_BANK_COUNT-1:0][OCC_W-1:0]  occ_next;
   logic [PRF_BANK_COUNT-1:0]             deq;
   logic                                  accept;
   logic                                  ready_next;

   // Lanes sharing a bank land in consecutive tail slots, lowest lane first.
   always_comb begin
      accept      = dealloc_ready & (|dealloc_valid_by_lane);
      lane_bank   = '0;
      lane_offset = '0;
      enq_count   = '0;
      occ_next    = '0;
      deq         = '0;
      ready_next  = 1'b1;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         lane_bank[i] = dealloc_pr_by_lane[i][LOG_BANK-1:0];
      end
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         for (int j = 0; j < i; j++) begin
            if (dealloc_valid_by_lane[j] && (lane_bank[j] == lane_bank[i])) begin
               lane_offset[i] = lane_offset[i] + PTR_W'(1);
            end
         end
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (accept && dealloc_valid_by_lane[i] && (lane_bank[i] == LOG_BANK'(b))) begin
               enq_count[b] = enq_count[b] + OCC_W'(1);
            end
         end
         deq[b]      = (occ[b] != '0) && free_ready_by_bank[b];
         occ_next[b] = occ[b] + enq_count[b] - OCC_W'(deq[b]);
         if (occ_next[b] > OCC_W'(ENTRIES_PER_BANK - COMMIT_WIDTH)) begin
            ready_next = 1'b0;
         end
      end
   end

   // Ready is precomputed from next occupancy so it never looks at the incoming valids.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head          <= '0;
         tail          <= '0;
         occ           <= '0;
         dealloc_ready <= 1'b1;
      end else begin
         for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (deq[b]) begin
               head[b] <= head[b] + PTR_W'(1);
            end
            tail[b] <= tail[b] + PTR_W'(enq_count[b]);
         end
         occ           <= occ_next;
         dealloc_ready <= ready_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && accept) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (dealloc_valid_by_lane[i]) begin
               mem[lane_bank[i]][tail[lane_bank[i]] + lane_offset[i]] <= dealloc_pr_by_lane[i];
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         free_valid_by_bank[b] = (occ[b] != '0);
         free_pr_by_bank[b]    = mem[b][head[b]];
      end
      occupancy_by_bank = occ;
   end

`ifdef ROB_PR_FREE_Q_PERF_EN
   logic [OCC_W-1:0] max_next;

   always_comb begin
      max_next = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         if (occ_next[b] > max_next) begin
            max_next = occ_next[b];
         end
      end
   end

   // Both counters saturate rather than wrap.
   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_stall_cycles  <= '0;
         perf_max_occupancy <= '0;
      end else begin
         if ((|dealloc_valid_by_lane) && !dealloc_ready && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (max_next > perf_max_occupancy) begin
            perf_max_occupancy <= max_next;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_pr_free_q.sv
// Self-checking bench for rob_pr_free_q: directed scenarios plus randomized traffic
// compared against per-bank queue model.
module tb_rob_pr_free_q;

   logic            clk;
   logic            rst;
   logic [3:0]      valid;
   logic [3:0][6:0] pr;
   logic            ready;
   logic [3:0]      free_valid;
   logic [3:0][6:0] free_pr;
   logic [3:0]      fready;
   logic [3:0][3:0] occ;
`ifdef ROB_PR_FREE_Q_PERF_EN
   logic [31:0]     perf_stall;
   logic [3:0]      perf_max;
`endif

   int checks = 0;
   int passes = 0;

   logic [6:0] mq [4][$];
   logic       m_ready = 1'b1;

   rob_pr_free_q dut (
      .CLK                   (clk),
      .RST                   (rst),
      .dealloc_valid_by_lane (valid),
      .dealloc_pr_by_lane    (pr),
      .dealloc_ready         (ready),
      .free_valid_by_bank    (free_valid),
      .free_pr_by_bank       (free_pr),
      .free_ready_by_bank    (fready),
      .occupancy_by_bank     (occ)
`ifdef ROB_PR_FREE_Q_PERF_EN
      ,
      .perf_stall_cycles     (perf_stall),
      .perf_max_occupancy    (perf_max)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one edge, updating the queue model from the inputs held across it.
   task automatic tick();
      logic acc;
      @(posedge clk);
      if (rst) begin
         for (int b = 0; b < 4; b++) mq[b].delete();
         m_ready = 1'b1;
      end else begin
         acc = m_ready && (valid != 4'b0);
         for (int b = 0; b < 4; b++) begin
            if (mq[b].size() != 0 && fready[b]) void'(mq[b].pop_front());
         end
         if (acc) begin
            for (int i = 0; i < 4; i++) begin
               if (valid[i]) mq[pr[i][1:0]].push_back(pr[i]);
            end
         end
         m_ready = 1'b1;
         for (int b = 0; b < 4; b++) begin
            if (mq[b].size() > 4) m_ready = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 4'hF; fready = 4'h0;
      pr = {7'h13, 7'h22, 7'h31, 7'h40};
      tick();
      tick();
      checks++; if (free_valid !== 4'h0) $display("[TB] FAIL reset_valid: got %h expected 0", free_valid); else passes++;
      checks++; if (occ !== 16'h0) $display("[TB] FAIL reset_occ: got %h expected 0", occ); else passes++;
      checks++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready); else passes++;
      rst = 1'b0; valid = 4'h0;
      tick();
      checks++; if (free_valid !== 4'h0 || occ !== 16'h0) $display("[TB] FAIL reset_nothing_queued: got valid %h occ %h expected 0 0", free_valid, occ); else passes++;
   endtask

   task automatic test_spread();
      logic [6:0] exp_pr [4] = '{7'h04, 7'h09, 7'h12, 7'h1F};
      valid = 4'hF; fready = 4'h0;
      pr = {7'h1F, 7'h12, 7'h09, 7'h04};
      tick();
      valid = 4'h0;
      checks++; if (free_valid !== 4'hF) $display("[TB] FAIL spread_valid: got %h expected f", free_valid); else passes++;
      for (int b = 0; b < 4; b++) begin
         checks++; if (free_pr[b] !== exp_pr[b]) $display("[TB] FAIL spread_pr%0d: got %h expected %h", b, free_pr[b], exp_pr[b]); else passes++;
         checks++; if (occ[b] !== 4'd1) $display("[TB] FAIL spread_occ%0d: got %0d expected 1", b, occ[b]); else passes++;
      end
      fready = 4'hF;
      tick();
      fready = 4'h0;
      checks++; if (free_valid !== 4'h0) $display("[TB] FAIL spread_drain: got %h expected 0", free_valid); else passes++;
   endtask

   task automatic test_same_bank_burst();
      logic [6:0] exp_pr [4] = '{7'h10, 7'h20, 7'h30, 7'h40};
      valid = 4'hF; fready = 4'h0;
      pr = {7'h40, 7'h30, 7'h20, 7'h10};
      tick();
      checks++; if (occ[0] !== 4'd4) $display("[TB] FAIL burst_occ4: got %0d expected 4", occ[0]); else passes++;
      checks++; if (ready !== 1'b1) $display("[TB] FAIL burst_ready_at4: got %b expected 1", ready); else passes++;
      tick();
      checks++; if (occ[0] !== 4'd8) $display("[TB] FAIL burst_occ8: got %0d expected 8", occ[0]); else passes++;
      checks++; if (ready !== 1'b0) $display("[TB] FAIL burst_ready_at8: got %b expected 0", ready); else passes++;
      tick();
      checks++; if (occ[0] !== 4'd8) $display("[TB] FAIL burst_no_overflow: got %0d expected 8", occ[0]); else passes++;
      valid = 4'h0; fready = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         checks++; if (free_pr[0] !== exp_pr[k % 4]) $display("[TB] FAIL burst_order%0d: got %h expected %h", k, free_pr[0], exp_pr[k % 4]); else passes++;
         checks++; if (occ[0] !== 4'(8 - k)) $display("[TB] FAIL burst_drain_occ%0d: got %0d expected %0d", k, occ[0], 8 - k); else passes++;
         checks++; if (ready !== ((8 - k) <= 4)) $display("[TB] FAIL burst_ready%0d: got %b expected %b", k, ready, (8 - k) <= 4); else passes++;
         tick();
      end
      fready = 4'h0;
      checks++; if (free_valid[0] !== 1'b0) $display("[TB] FAIL burst_empty: got %b expected 0", free_valid[0]); else passes++;
   endtask

   task automatic test_simultaneous();
      logic [6:0] e;
      valid = 4'b0111; fready = 4'h0;
      pr = {7'h00, 7'h0A, 7'h06, 7'h02};
      tick();
      checks++; if (occ[2] !== 4'd3) $display("[TB] FAIL simul_occ3: got %0d expected 3", occ[2]); else passes++;
      valid = 4'b0011; fready = 4'b0100;
      pr = {7'h00, 7'h00, 7'h12, 7'h0E};
      tick();
      valid = 4'h0; fready = 4'h0;
      checks++; if (occ[2] !== 4'd4) $display("[TB] FAIL simul_occ4: got %0d expected 4", occ[2]); else passes++;
      checks++; if (free_pr[2] !== 7'h06) $display("[TB] FAIL simul_head: got %h expected 06", free_pr[2]); else passes++;
      fready = 4'b0100;
      repeat (4) tick();
      fready = 4'h0;
      checks++; if (free_valid[2] !== 1'b0) $display("[TB] FAIL simul_drain: got %b expected 0", free_valid[2]); else passes++;
      for (int f = 0; f < 3; f++) begin
         valid = 4'hF;
         for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 4; i++) pr[i] = 7'(((f * 8 + h * 4 + i) * 4) + 2);
            tick();
         end
         valid = 4'h0;
         checks++; if (occ[2] !== 4'd8) $display("[TB] FAIL wrap_fill%0d: got %0d expected 8", f, occ[2]); else passes++;
         fready = 4'b0100;
         for (int k = 0; k < 8; k++) begin
            e = 7'(((f * 8 + k) * 4) + 2);
            checks++; if (free_pr[2] !== e) $display("[TB] FAIL wrap_order%0d_%0d: got %h expected %h", f, k, free_pr[2], e); else passes++;
            tick();
         end
         fready = 4'h0;
         checks++; if (free_valid[2] !== 1'b0) $display("[TB] FAIL wrap_empty%0d: got %b expected 0", f, free_valid[2]); else passes++;
      end
   endtask

   task automatic test_midop_reset();
      valid = 4'hF; fready = 4'h0;
      pr = {7'h0D, 7'h09, 7'h05, 7'h01};
      tick();
      valid = 4'b0011;
      pr = {7'h00, 7'h00, 7'h15, 7'h11};
      tick();
      checks++; if (occ[1] !== 4'd6) $display("[TB] FAIL midrst_occ6: got %0d expected 6", occ[1]); else passes++;
      rst = 1'b1; valid = 4'hF; fready = 4'b0010;
      pr = {7'h25, 7'h21, 7'h1D, 7'h19};
      tick();
      rst = 1'b0; valid = 4'h0;
      checks++; if (free_valid !== 4'h0) $display("[TB] FAIL midrst_valid: got %h expected 0", free_valid); else passes++;
      checks++; if (occ !== 16'h0) $display("[TB] FAIL midrst_occ: got %h expected 0", occ); else passes++;
      checks++; if (ready !== 1'b1) $display("[TB] FAIL midrst_ready: got %b expected 1", ready); else passes++;
      fready = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (free_valid !== 4'h0) $display("[TB] FAIL midrst_stale%0d: got %h expected 0", k, free_valid); else passes++;
      end
      fready = 4'h0;
   endtask

   task automatic test_random();
      int errs;
      for (int n = 0; n < 500; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         valid = 4'($urandom);
         for (int i = 0; i < 4; i++) pr[i] = 7'($urandom);
         for (int b = 0; b < 4; b++) fready[b] = ($urandom_range(0, 9) < 4);
         tick();
         errs = 0;
         checks++;
         if (ready !== m_ready) begin
            $display("[TB] FAIL rand_ready@%0d: got %b expected %b", n, ready, m_ready);
            errs++;
         end
         for (int b = 0; b < 4; b++) begin
            if (occ[b] !== 4'(mq[b].size()) || occ[b] > 4'd8) begin
               $display("[TB] FAIL rand_occ%0d@%0d: got %0d expected %0d", b, n, occ[b], mq[b].size());
               errs++;
            end
            if (free_valid[b] !== (mq[b].size() != 0)) begin
               $display("[TB] FAIL rand_valid%0d@%0d: got %b expected %b", b, n, free_valid[b], mq[b].size() != 0);
               errs++;
            end else if (mq[b].size() != 0 && free_pr[b] !== mq[b][0]) begin
               $display("[TB] FAIL rand_pr%0d@%0d: got %h expected %h", b, n, free_pr[b], mq[b][0]);
               errs++;
            end
         end
         if (errs == 0) passes++;
      end
      rst = 1'b0; valid = 4'h0; fready = 4'h0;
   endtask

`ifdef ROB_PR_FREE_Q_PERF_EN
   task automatic test_perf();
      rst = 1'b1; valid = 4'h0; fready = 4'h0;
      tick();
      rst = 1'b0; valid = 4'hF;
      pr = {7'h0C, 7'h08, 7'h04, 7'h00};
      tick();
      tick();
      checks++; if (perf_stall !== 32'd0) $display("[TB] FAIL perf_no_stall: got %0d expected 0", perf_stall); else passes++;
      repeat (5) tick();
      valid = 4'h0;
      checks++; if (perf_stall !== 32'd5) $display("[TB] FAIL perf_stall: got %0d expected 5", perf_stall); else passes++;
      checks++; if (perf_max !== 4'd8) $display("[TB] FAIL perf_max: got %0d expected 8", perf_max); else passes++;
   endtask
`endif

   initial begin
      rst = 1'b1; valid = 4'h0; pr = '0; fready = 4'h0;
      test_reset();
      test_spread();
      test_same_bank_burst();
      test_simultaneous();
      test_midop_reset();
      test_random();
`ifdef ROB_PR_FREE_Q_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
